// File: rtl/in_req_unit_pkg.sv
// Shared router constants, the requester FSM state type and the one-hot
// destination decoder used by in_req_unit.
package in_req_unit_pkg;

   localparam int unsigned PKT_W    = 64;
   localparam int unsigned NUM_OUT  = 8;
   localparam int unsigned DEST_LSB = 48;
   localparam int unsigned DEST_W   = $clog2(NUM_OUT);

   // Widest request vector oh_decode can produce; callers slice it down.
   localparam int unsigned OH_MAX   = 64;

   typedef enum logic {
      ST_EMPTY = 1'b0,   // no buffered packet, no request
      ST_REQ   = 1'b1    // head packet present, request held
   } req_state_e;

   // One-hot of idx within an n-wide vector; all zeros when idx is out of range.
   function automatic logic [OH_MAX-1:0] oh_decode(input int unsigned idx,
                                                   input int unsigned n);
      logic [OH_MAX-1:0] v;
      v = {{(OH_MAX-1){1'b0}}, 1'b1} << idx;
      if (!(idx < n && idx < OH_MAX)) begin
         v = '0;
      end
      return v;
   endfunction

endpackage

// File: rtl/in_req_unit_pkt_fifo.sv
// Packet FIFO: DEPTH x W storage with read/write pointers and an occupancy
// count. The head entry is presented combinationally on o_rdata.
//  clk      in   rising-edge clock
//  reset    in   asynchronous active-low reset (pointers and count only)
//  i_push   in   write i_wdata at the tail (ignored when full)
//  i_pop    in   drop the head entry (ignored when empty)
//  i_wdata  in   W-bit write data
//  o_rdata  out  W-bit head entry
//  o_count  out  number of stored entries
//  o_full   out  count == DEPTH
//  o_empty  out  count == 0
module pkt_fifo #(
   parameter int unsigned W     = 64,
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [W-1:0]             i_wdata,
   output logic [W-1:0]             o_rdata,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rd_ptr];

   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop  & ~o_empty;

   // DEPTH is a power of two, so pointer increment wraps DEPTH-1 -> 0 naturally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/in_req_unit.sv
// Requester end of the output-port arbitration interface (one per router
// input port). Buffers packets, decodes the head packet's destination into a
// one-hot request, pops the head on the granting edge, counts stall cycles
// and flags grant protocol violations.
//  clk       in   rising-edge clock
//  reset     in   asynchronous active-low reset
//  in_valid  in   upstream packet present
//  in_ready  out  FIFO can accept a packet
//  in_data   in   upstream packet
//  req_out   out  one-hot request, bit k to arbiter k
//  gnt_in    in   this port's grant bit from each arbiter
//  out_valid out  head packet transferred this cycle
//  out_data  out  head packet (0 when empty)
//  stall_cnt out  cycles the current head has waited ungranted (saturating)
//  gnt_err   out  sticky protocol-violation flag
module in_req_unit #(
   parameter int unsigned PKT_W    = in_req_unit_pkg::PKT_W,
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned NUM_OUT  = in_req_unit_pkg::NUM_OUT,
   parameter int unsigned DEST_LSB = in_req_unit_pkg::DEST_LSB,
   parameter int unsigned CNT_W    = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PKT_W-1:0]   in_data,
   output logic [NUM_OUT-1:0] req_out,
   input  logic [NUM_OUT-1:0] gnt_in,
   output logic               out_valid,
   output logic [PKT_W-1:0]   out_data,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic               gnt_err
);

   import in_req_unit_pkg::*;

   localparam int unsigned DW  = $clog2(NUM_OUT);
   localparam int unsigned CW  = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0]    COUNT_ONE = CW'(1);
   localparam logic [CNT_W-1:0] STALL_MAX = '1;

   logic               w_push;
   logic               w_pop;
   logic               w_full;
   logic               w_empty;
   logic [PKT_W-1:0]   w_head;
   logic [CW-1:0]      w_count;
   logic [DW-1:0]      w_dest;
   logic [OH_MAX-1:0]  w_oh_full;
   logic [NUM_OUT-1:0] w_req;
   logic               w_dest_bad;
   logic               w_gnt_stray;
   logic               w_gnt_multi;
   req_state_e         r_state;
   req_state_e         w_state_nxt;
   logic [CNT_W-1:0]   r_stall;
   logic               r_gnt_err;

   pkt_fifo #(
      .W     (PKT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (in_data),
      .o_rdata (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Registered state only: no path from gnt_in, and a full FIFO refuses a
   // push even when the head is popping in the same cycle.
   assign in_ready = ~w_full;
   assign w_push   = in_valid & ~w_full;

   assign w_dest    = w_head[DEST_LSB +: DW];
   assign w_oh_full = oh_decode(32'(w_dest), NUM_OUT);

   // Request is a function of registers only, so the arbiter sees no loop.
   assign w_req      = (r_state == ST_REQ) ? w_oh_full[NUM_OUT-1:0] : '0;
   assign w_dest_bad = (r_state == ST_REQ) && (w_oh_full[NUM_OUT-1:0] == '0);

   assign w_pop = |(gnt_in & w_req);

   assign w_gnt_stray = |(gnt_in & ~w_req);
   assign w_gnt_multi = |(gnt_in & (gnt_in - 1'b1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_EMPTY;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_EMPTY: if (w_push) w_state_nxt = ST_REQ;
         ST_REQ:   if (w_pop && (w_count == COUNT_ONE) && !w_push) w_state_nxt = ST_EMPTY;
         default:  w_state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall   <= '0;
         r_gnt_err <= 1'b0;
      end else begin
         if (w_pop || w_empty) begin
            r_stall <= '0;
         end else if ((|w_req) && (r_stall != STALL_MAX)) begin
            r_stall <= r_stall + 1'b1;
         end
         if (w_gnt_stray || w_gnt_multi || w_dest_bad) begin
            r_gnt_err <= 1'b1;
         end
      end
   end

   assign req_out   = w_req;
   assign out_valid = w_pop;
   assign out_data  = w_empty ? '0 : w_head;
   assign stall_cnt = r_stall;
   assign gnt_err   = r_gnt_err;

endmodule
